// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
// Fetch-stage program-counter generator feeding the branch history table.
// Each cycle the current fetch PC is presented on if_pc; the next PC is
// chosen from (highest priority first) an execute-stage redirect, a held
// value during a stall, the table's taken prediction, or sequential PC+4.
// The prediction made for each fetched instruction travels with it through
// ID and EX so the table's update logic can compare it with the resolved
// outcome. A redirect squashes both in-flight slots.
//
// Parameters
//   RESET_PC      fetch address after reset
//   CNT_W         width of the saturating redirect counter (>= 2)
// Ports
//   clk_sys       in   system clock, rising-edge active
//   rst_n         in   asynchronous active-low reset
//   stall         in   hazard hold; freezes PC and metadata
//   bht_hit       in   table predicts taken for if_pc
//   bht_npc       in   predicted target for if_pc
//   pcclear       in   mispredict flag for the EX instruction
//   ex_taken      in   resolved outcome of the EX instruction
//   ex_target     in   resolved target of the EX instruction
//   ex_pc         in   PC of the EX instruction
//   if_pc         out  current fetch PC
//   id_pc         out  PC of the instruction in ID
//   id_valid      out  ID slot holds a real instruction
//   ex_pred       out  EX instruction was predicted taken (0 for bubbles)
//   ex_pred_npc   out  predicted target of the EX instruction (0 for bubbles)
//   ex_valid      out  EX slot holds a real instruction
//   redirect_cnt  out  saturating count of redirects

module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk_sys,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             bht_hit,
   input  logic [31:0]      bht_npc,
   input  logic             pcclear,
   input  logic             ex_taken,
   input  logic [31:0]      ex_target,
   input  logic [31:0]      ex_pc,
   output logic [31:0]      if_pc,
   output logic [31:0]      id_pc,
   output logic             id_valid,
   output logic             ex_pred,
   output logic [31:0]      ex_pred_npc,
   output logic             ex_valid,
   output logic [CNT_W-1:0] redirect_cnt
);

   // Fetch PC and its next value
   logic [31:0]      r_if_pc;
   logic [31:0]      w_if_pc_nxt;
   logic [31:0]      w_seq_pc;
   logic [31:0]      w_redirect_pc;

   // ID slot
   logic             r_id_valid;
   logic [31:0]      r_id_pc;
   logic             r_id_pred;
   logic [31:0]      r_id_pred_npc;
   logic             w_id_valid_nxt;
   logic [31:0]      w_id_pc_nxt;
   logic             w_id_pred_nxt;
   logic [31:0]      w_id_pred_npc_nxt;

   // EX slot. The prediction fields are stored already masked by the
   // slot's validity, so a bubble can never present a prediction to the
   // table. The EX PC itself is not kept: the execute stage supplies it.
   logic             r_ex_valid;
   logic             r_ex_pred;
   logic [31:0]      r_ex_pred_npc;
   logic             w_ex_valid_nxt;
   logic             w_ex_pred_nxt;
   logic [31:0]      w_ex_pred_npc_nxt;

   // Redirect counter
   logic [CNT_W-1:0] r_redirect_cnt;
   logic [CNT_W-1:0] w_redirect_cnt_nxt;
   logic             w_cnt_sat;

   // Both adds wrap modulo 2^32 by construction (32-bit result).
   assign w_seq_pc      = r_if_pc + 32'd4;
   assign w_redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);
   assign w_cnt_sat     = (r_redirect_cnt == {CNT_W{1'b1}});

   // Next fetch PC: redirect, then stall hold, then prediction, then PC+4
   always_comb begin
      w_if_pc_nxt = r_if_pc;
      if (pcclear) begin
         w_if_pc_nxt = w_redirect_pc;
      end else if (stall) begin
         w_if_pc_nxt = r_if_pc;
      end else if (bht_hit) begin
         w_if_pc_nxt = bht_npc;
      end else begin
         w_if_pc_nxt = w_seq_pc;
      end
   end

   // Next ID/EX metadata: squash on redirect (even when stalled), hold on
   // stall, otherwise advance IF->ID->EX
   always_comb begin
      w_id_valid_nxt    = r_id_valid;
      w_id_pc_nxt       = r_id_pc;
      w_id_pred_nxt     = r_id_pred;
      w_id_pred_npc_nxt = r_id_pred_npc;
      w_ex_valid_nxt    = r_ex_valid;
      w_ex_pred_nxt     = r_ex_pred;
      w_ex_pred_npc_nxt = r_ex_pred_npc;
      if (pcclear) begin
         w_id_valid_nxt    = 1'b0;
         w_ex_valid_nxt    = 1'b0;
         w_ex_pred_nxt     = 1'b0;
         w_ex_pred_npc_nxt = 32'h0000_0000;
      end else if (stall) begin
         w_id_valid_nxt    = r_id_valid;
         w_ex_valid_nxt    = r_ex_valid;
      end else begin
         w_id_valid_nxt    = 1'b1;
         w_id_pc_nxt       = r_if_pc;
         w_id_pred_nxt     = bht_hit;
         w_id_pred_npc_nxt = bht_npc;
         w_ex_valid_nxt    = r_id_valid;
         w_ex_pred_nxt     = r_id_valid & r_id_pred;
         w_ex_pred_npc_nxt = r_id_valid ? r_id_pred_npc : 32'h0000_0000;
      end
   end

   // Next redirect count, sticking at all-ones
   always_comb begin
      w_redirect_cnt_nxt = r_redirect_cnt;
      if (pcclear && !w_cnt_sat) begin
         w_redirect_cnt_nxt = r_redirect_cnt + CNT_W'(1);
      end else begin
         w_redirect_cnt_nxt = r_redirect_cnt;
      end
   end

   // Fetch PC register
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_if_pc <= RESET_PC;
      end else begin
         r_if_pc <= w_if_pc_nxt;
      end
   end

   // ID slot registers
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_id_valid    <= 1'b0;
         r_id_pc       <= 32'h0000_0000;
         r_id_pred     <= 1'b0;
         r_id_pred_npc <= 32'h0000_0000;
      end else begin
         r_id_valid    <= w_id_valid_nxt;
         r_id_pc       <= w_id_pc_nxt;
         r_id_pred     <= w_id_pred_nxt;
         r_id_pred_npc <= w_id_pred_npc_nxt;
      end
   end

   // EX slot registers
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_valid    <= 1'b0;
         r_ex_pred     <= 1'b0;
         r_ex_pred_npc <= 32'h0000_0000;
      end else begin
         r_ex_valid    <= w_ex_valid_nxt;
         r_ex_pred     <= w_ex_pred_nxt;
         r_ex_pred_npc <= w_ex_pred_npc_nxt;
      end
   end

   // Redirect counter register
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_redirect_cnt <= {CNT_W{1'b0}};
      end else begin
         r_redirect_cnt <= w_redirect_cnt_nxt;
      end
   end

   assign if_pc        = r_if_pc;
   assign id_pc        = r_id_pc;
   assign id_valid     = r_id_valid;
   assign ex_valid     = r_ex_valid;
   assign ex_pred      = r_ex_pred;
   assign ex_pred_npc  = r_ex_pred_npc;
   assign redirect_cnt = r_redirect_cnt;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit. Two instances share one stimulus:
// u_dut uses the default 16-bit counter, u_dut2 a 2-bit counter to reach
// saturation quickly. A per-instruction model tracks the fetch PC and the
// two in-flight slots; a negedge process compares both instances with it
// every cycle, and directed steps pin literal values.

module tb_fetch_pc_unit;

   localparam logic [31:0] RPC = 32'h0000_0100;

   logic        clk_sys = 1'b0;
   logic        rst_n;
   logic        stall, bht_hit, pcclear, ex_taken;
   logic [31:0] bht_npc, ex_target, ex_pc;

   logic [31:0] if_pc_a, id_pc_a, ex_pred_npc_a;
   logic        id_valid_a, ex_pred_a, ex_valid_a;
   logic [15:0] cnt_a;
   logic [31:0] if_pc_b, id_pc_b, ex_pred_npc_b;
   logic        id_valid_b, ex_pred_b, ex_valid_b;
   logic [1:0]  cnt_b;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   fetch_pc_unit #(.RESET_PC(RPC), .CNT_W(16)) u_dut (
      .clk_sys(clk_sys), .rst_n(rst_n), .stall(stall), .bht_hit(bht_hit),
      .bht_npc(bht_npc), .pcclear(pcclear), .ex_taken(ex_taken),
      .ex_target(ex_target), .ex_pc(ex_pc), .if_pc(if_pc_a), .id_pc(id_pc_a),
      .id_valid(id_valid_a), .ex_pred(ex_pred_a), .ex_pred_npc(ex_pred_npc_a),
      .ex_valid(ex_valid_a), .redirect_cnt(cnt_a));

   fetch_pc_unit #(.RESET_PC(RPC), .CNT_W(2)) u_dut2 (
      .clk_sys(clk_sys), .rst_n(rst_n), .stall(stall), .bht_hit(bht_hit),
      .bht_npc(bht_npc), .pcclear(pcclear), .ex_taken(ex_taken),
      .ex_target(ex_target), .ex_pc(ex_pc), .if_pc(if_pc_b), .id_pc(id_pc_b),
      .id_valid(id_valid_b), .ex_pred(ex_pred_b), .ex_pred_npc(ex_pred_npc_b),
      .ex_valid(ex_valid_b), .redirect_cnt(cnt_b));

   always #5 clk_sys = ~clk_sys;

   // ---------------- model ----------------
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        pred;
      logic [31:0] npc;
   } slot_t;

   logic [31:0] m_pc;
   slot_t       m_id, m_ex;
   int          m_redirects;

   always @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         m_pc        <= RPC;
         m_id        <= '0;
         m_ex        <= '0;
         m_redirects <= 0;
      end else if (pcclear) begin
         m_pc        <= ex_taken ? ex_target : 32'((64'(ex_pc) + 64'd4) % 64'h1_0000_0000);
         m_id.valid  <= 1'b0;
         m_ex.valid  <= 1'b0;
         m_redirects <= m_redirects + 1;
      end else if (!stall) begin
         m_pc <= bht_hit ? bht_npc : 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
         m_id <= '{valid: 1'b1, pc: m_pc, pred: bht_hit, npc: bht_npc};
         m_ex <= m_id;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_set(input string tag, input logic [31:0] ipc, input logic [31:0] ipcid,
                          input logic iv, input logic ep, input logic [31:0] enpc,
                          input logic ev, input logic [31:0] cnt, input int sat);
      int exp_cnt;
      exp_cnt = (m_redirects > sat) ? sat : m_redirects;
      chk({tag, ".if_pc"},    ipc, m_pc);
      chk({tag, ".id_valid"}, 32'(iv), 32'(m_id.valid));
      if (m_id.valid) chk({tag, ".id_pc"}, ipcid, m_id.pc);
      if (!rst_n)     chk({tag, ".id_pc_rst"}, ipcid, 32'h0);
      chk({tag, ".ex_valid"}, 32'(ev), 32'(m_ex.valid));
      chk({tag, ".ex_pred"},  32'(ep), 32'(m_ex.valid && m_ex.pred));
      chk({tag, ".ex_pred_npc"}, enpc, m_ex.valid ? m_ex.npc : 32'h0);
      chk({tag, ".redirect_cnt"}, cnt, 32'(exp_cnt));
   endtask

   // Every-cycle comparison of both instances against the model
   always @(negedge clk_sys) begin
      if (chk_en) begin
         cmp_set("a", if_pc_a, id_pc_a, id_valid_a, ex_pred_a, ex_pred_npc_a,
                 ex_valid_a, 32'(cnt_a), 65535);
         cmp_set("b", if_pc_b, id_pc_b, id_valid_b, ex_pred_b, ex_pred_npc_b,
                 ex_valid_b, 32'(cnt_b), 3);
      end
   end

   // Apply one cycle of inputs just after a negedge, return at the next negedge
   task automatic step(input logic st, input logic hit, input logic [31:0] npc,
                       input logic clr, input logic tk, input logic [31:0] tgt,
                       input logic [31:0] epc);
      #1;
      stall = st; bht_hit = hit; bht_npc = npc;
      pcclear = clr; ex_taken = tk; ex_target = tgt; ex_pc = epc;
      @(negedge clk_sys);
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 1'b0; bht_hit = 1'b0; bht_npc = 32'h0; pcclear = 1'b0;
      ex_taken = 1'b0; ex_target = 32'h0; ex_pc = 32'h0;
      repeat (2) @(negedge clk_sys);
      chk_en = 1'b1;

      // reset values
      chk("rst.if_pc", if_pc_a, 32'h100);
      chk("rst.id_valid", 32'(id_valid_a), 32'h0);
      chk("rst.ex_pred_npc", ex_pred_npc_a, 32'h0);

      // release and sequential fetch
      #1 rst_n = 1'b1;
      @(negedge clk_sys);
      chk("seq1.if_pc", if_pc_a, 32'h104);
      chk("seq1.id_pc", id_pc_a, 32'h100);
      chk("seq1.ex_valid", 32'(ex_valid_a), 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("seq2.if_pc", if_pc_a, 32'h108);
      chk("seq2.ex_valid", 32'(ex_valid_a), 32'h1);

      // taken prediction at 0x108
      step(1'b0, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("pred.if_pc", if_pc_a, 32'h400);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("pred.ex_pred", 32'(ex_pred_a), 32'h1);
      chk("pred.ex_pred_npc", ex_pred_npc_a, 32'h400);

      // mispredict, not taken
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h108);
      chk("mis.if_pc", if_pc_a, 32'h10C);
      chk("mis.id_valid", 32'(id_valid_a), 32'h0);
      chk("mis.ex_pred", 32'(ex_pred_a), 32'h0);
      chk("mis.cnt", 32'(cnt_a), 32'h1);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

      // redirect beats stall and prediction
      step(1'b1, 1'b1, 32'h800, 1'b1, 1'b1, 32'h200, 32'h10C);
      chk("ovr.if_pc", if_pc_a, 32'h200);
      chk("ovr.ex_valid", 32'(ex_valid_a), 32'h0);
      step(1'b1, 1'b1, 32'h800, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b1, 1'b1, 32'h800, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("ovr.hold", if_pc_a, 32'h200);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("ovr.resume", if_pc_a, 32'h204);

      // wrap-around of redirect and sequential adds, counter saturation
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC);
      chk("wrap.redir", if_pc_a, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0);
      chk("sat.cnt_b4", 32'(cnt_b), 32'h3);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("wrap.seq", if_pc_a, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 32'h50);
      chk("sat.cnt_b5", 32'(cnt_b), 32'h3);
      chk("sat.cnt_a5", 32'(cnt_a), 32'h5);

      // stall mid-stream: no lost or duplicated fetch
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b1, 1'b1, 32'h900, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("stall.if_pc", if_pc_a, 32'h308);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("stall.resume", if_pc_a, 32'h30C);
      chk("stall.id_pc", id_pc_a, 32'h308);
      chk("stall.ex_valid", 32'(ex_valid_a), 32'h1);

      // async reset mid-pipeline with a redirect pending
      #1 pcclear = 1'b1; ex_taken = 1'b1; ex_target = 32'h700;
      #2 rst_n = 1'b0;
      #1;
      chk("arst.if_pc", if_pc_a, 32'h100);
      chk("arst.ex_valid", 32'(ex_valid_a), 32'h0);
      chk("arst.id_valid", 32'(id_valid_a), 32'h0);
      chk("arst.cnt", 32'(cnt_a), 32'h0);
      @(negedge clk_sys);
      chk("arst.hold", if_pc_a, 32'h100);
      #1 pcclear = 1'b0; ex_taken = 1'b0; rst_n = 1'b1;
      @(negedge clk_sys);
      chk("arst.release", if_pc_a, 32'h104);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
